uart_frame_deframer: RTL and testbench

Byte-stream frame deframer sitting directly downstream of the UART receiver. It consumes the 8-bit AXI4-Stream bytes the receiver produces and recognises frames of the form SOF, LEN, payload, CHK. Each payload is buffered internally and released as an AXI4-Stream packet with tlast only after the checksum passes. Frames that are malformed, fail the checksum or time out are dropped, and an error pulse is raised for each.

---
 rtl/uart_frame_deframer_if.sv | 20 ++
 rtl/uart_frame_deframer.sv | 205 ++++++++++++++++++++
 tb/tb_uart_frame_deframer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_deframer_if.sv
// Stream bundle for the frame deframer: received UART bytes in, checked payload packets out.
interface uart_frame_deframer_if;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/uart_frame_deframer.sv
// Recognises SOF/LEN/payload/CHK frames, buffers the payload and releases it only after the checksum passes.
// Optional inter-byte timeout is compiled in with UART_DEFRAMER_TIMEOUT_EN.
module uart_frame_deframer #(
  parameter int         MAX_LEN        = 64,
  parameter logic [7:0] SOF            = 8'h7E,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_frame_deframer_if.slave  axis,
  output logic                  busy,
  output logic                  frame_good,
  output logic                  checksum_error,
  output logic                  length_error,
  output logic                  timeout_error
);
  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("uart_frame_deframer: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHECK, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    len_reg, len_next;
  logic [7:0]    sum_reg, sum_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] rd_ptr_inc;
  logic          m_valid_reg, m_valid_next;
  logic          m_last_reg, m_last_next;
  logic [7:0]    m_data_reg;
  logic          good_reg, good_next;
  logic          chk_err_reg, chk_err_next;
  logic          len_err_reg, len_err_next;
  logic          accept, out_fire, mem_we, load_out;
  logic [AW-1:0] rd_addr;
  logic [7:0]    chk_total;
  logic [7:0]    mem [2**AW];

`ifdef UART_DEFRAMER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_cnt_reg, idle_cnt_next;
  logic        timeout_reg, timeout_next;
`endif

  assign accept     = axis.s_axis_tvalid && (state_reg != DRAIN);
  assign out_fire   = m_valid_reg && axis.m_axis_tready;
  assign rd_ptr_inc = rd_ptr_reg + PW'(1);
  assign chk_total  = sum_reg + axis.s_axis_tdata;

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    sum_next     = sum_reg;
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    m_valid_next = m_valid_reg;
    m_last_next  = m_last_reg;
    good_next    = 1'b0;
    chk_err_next = 1'b0;
    len_err_next = 1'b0;
    mem_we       = 1'b0;
    load_out     = 1'b0;
    rd_addr      = rd_ptr_reg[AW-1:0];
`ifdef UART_DEFRAMER_TIMEOUT_EN
    idle_cnt_next = idle_cnt_reg;
    timeout_next  = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (accept && axis.s_axis_tdata == SOF) state_next = LEN;
      end
      LEN: begin
        if (accept) begin
          if (axis.s_axis_tdata != 8'd0 && axis.s_axis_tdata <= MAX_LEN_B) begin
            len_next    = axis.s_axis_tdata;
            sum_next    = axis.s_axis_tdata;
            wr_ptr_next = '0;
            state_next  = PAYLOAD;
          end else begin
            len_err_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          mem_we      = 1'b1;
          sum_next    = sum_reg + axis.s_axis_tdata;
          wr_ptr_next = wr_ptr_reg + PW'(1);
          if (8'(wr_ptr_reg) == len_reg - 8'd1) state_next = CHECK;
        end
      end
      CHECK: begin
        if (accept) begin
          if (chk_total == 8'd0) begin
            // Prefetch byte 0 so the first beat is valid in the first DRAIN cycle.
            good_next    = 1'b1;
            rd_ptr_next  = '0;
            rd_addr      = '0;
            load_out     = 1'b1;
            m_valid_next = 1'b1;
            m_last_next  = (len_reg == 8'd1);
            state_next   = DRAIN;
          end else begin
            chk_err_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (m_last_reg) begin
            m_valid_next = 1'b0;
            m_last_next  = 1'b0;
            state_next   = IDLE;
          end else begin
            rd_ptr_next = rd_ptr_inc;
            rd_addr     = rd_ptr_inc[AW-1:0];
            load_out    = 1'b1;
            m_last_next = (8'(rd_ptr_inc) == len_reg - 8'd1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef UART_DEFRAMER_TIMEOUT_EN
    if (state_reg == LEN || state_reg == PAYLOAD || state_reg == CHECK) begin
      if (accept) begin
        idle_cnt_next = '0;
      end else if (idle_cnt_reg == TO_LAST) begin
        idle_cnt_next = '0;
        timeout_next  = 1'b1;
        state_next    = IDLE;
      end else begin
        idle_cnt_next = idle_cnt_reg + 16'd1;
      end
    end else if (state_next == LEN) begin
      idle_cnt_next = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      len_reg     <= '0;
      sum_reg     <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
      good_reg    <= 1'b0;
      chk_err_reg <= 1'b0;
      len_err_reg <= 1'b0;
`ifdef UART_DEFRAMER_TIMEOUT_EN
      idle_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      sum_reg     <= sum_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      m_valid_reg <= m_valid_next;
      m_last_reg  <= m_last_next;
      good_reg    <= good_next;
      chk_err_reg <= chk_err_next;
      len_err_reg <= len_err_next;
`ifdef UART_DEFRAMER_TIMEOUT_EN
      idle_cnt_reg <= idle_cnt_next;
      timeout_reg  <= timeout_next;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_reg[AW-1:0]] <= axis.s_axis_tdata;
  end

  // Output data only reloads on a handshake or DRAIN entry, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_data_reg <= '0;
    else if (load_out) m_data_reg <= mem[rd_addr];
  end

  assign axis.s_axis_tready = (state_reg != DRAIN);
  assign axis.m_axis_tdata  = m_data_reg;
  assign axis.m_axis_tvalid = m_valid_reg;
  assign axis.m_axis_tlast  = m_last_reg;
  assign busy               = (state_reg != IDLE);
  assign frame_good         = good_reg;
  assign checksum_error     = chk_err_reg;
  assign length_error       = len_err_reg;
`ifdef UART_DEFRAMER_TIMEOUT_EN
  assign timeout_error = timeout_reg;
`else
  assign timeout_error = 1'b0;
`endif
endmodule

// File: tb/tb_uart_frame_deframer.sv
// Directed scoreboard bench for uart_frame_deframer (MAX_LEN 64, TIMEOUT_CYCLES 100).
module tb_uart_frame_deframer;
  localparam int MAX_LEN = 64;
  localparam int TO      = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, frame_good, checksum_error, length_error, timeout_error;

  uart_frame_deframer_if axis();

  uart_frame_deframer #(.MAX_LEN(MAX_LEN), .SOF(8'h7E), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .axis(axis),
    .busy(busy),
    .frame_good(frame_good),
    .checksum_error(checksum_error),
    .length_error(length_error),
    .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];
  int fg_cnt, ce_cnt, le_cnt, to_cnt, tv_cnt, nrdy_cnt, tick_cnt, to_cyc;
  logic prev_stall = 1'b0;
  logic [9:0] prev_out = '0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic zero();
    fg_cnt = 0; ce_cnt = 0; le_cnt = 0; to_cnt = 0;
    tv_cnt = 0; nrdy_cnt = 0; tick_cnt = 0; to_cyc = -1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // Samples what the next rising edge will see, then advances to the following falling edge.
  task automatic tick();
    logic [8:0] e;
    if (rst_n) begin
      tick_cnt++;
      if (frame_good) fg_cnt++;
      if (checksum_error) ce_cnt++;
      if (length_error) le_cnt++;
      if (timeout_error) begin to_cnt++; to_cyc = tick_cnt; end
      if (axis.m_axis_tvalid) tv_cnt++;
      if (!axis.s_axis_tready) nrdy_cnt++;
      if (prev_stall)
        check("hold_stable", {6'd0, axis.m_axis_tvalid, axis.m_axis_tlast, axis.m_axis_tdata}, {6'd0, prev_out});
      if (axis.m_axis_tvalid && axis.m_axis_tready) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL sb_underflow: observed %0h expected none", {axis.m_axis_tlast, axis.m_axis_tdata});
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_beat", {7'd0, axis.m_axis_tlast, axis.m_axis_tdata}, {7'd0, e});
          $display("[TB] out %02h last=%0d", axis.m_axis_tdata, axis.m_axis_tlast);
        end
      end
      prev_stall = axis.m_axis_tvalid && !axis.m_axis_tready;
      prev_out   = {axis.m_axis_tvalid, axis.m_axis_tlast, axis.m_axis_tdata};
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    axis.s_axis_tdata  = b;
    axis.s_axis_tvalid = 1'b1;
    while (!axis.s_axis_tready && n < 200) begin tick(); n++; end
    tests++;
    assert (n < 200) else begin
      fails++;
      $error("FAIL send_wait: observed no s_axis_tready for byte %02h expected ready", b);
    end
    tick();
    axis.s_axis_tvalid = 1'b0;
    $display("[TB] in  %02h", b);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin tick(); n++; end
    tests++;
    assert (n < 200) else begin
      fails++;
      $error("FAIL drain_wait: observed %0d beats pending expected 0", exp_q.size());
    end
    tick();
    tick();
  endtask

  task automatic good_frame();
    push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b0); push_exp(8'h33, 1'b1);
    send(8'h7E); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
  endtask

  initial begin
    axis.s_axis_tdata  = '0;
    axis.s_axis_tvalid = 1'b0;
    axis.m_axis_tready = 1'b1;
    zero();
    @(negedge clk); @(negedge clk);
    // Reset state
    check("rst_s_tready", {15'd0, axis.s_axis_tready}, 16'd1);
    check("rst_outputs", {8'd0, axis.m_axis_tvalid, axis.m_axis_tlast, busy, frame_good,
                          checksum_error, length_error, timeout_error, 1'b0}, 16'd0);
    check("rst_tdata", {8'd0, axis.m_axis_tdata}, 16'd0);
    rst_n = 1'b1;
    tick();

    // Good frame, back-to-back, first beat valid in the cycle after CHK
    zero();
    good_frame();
    check("first_valid", {15'd0, axis.m_axis_tvalid}, 16'd1);
    check("good_pulse_latency", {15'd0, frame_good}, 16'd1);
    wait_drain();
    check("good_fg_cnt", 16'(fg_cnt), 16'd1);
    check("good_tv_cycles", 16'(tv_cnt), 16'd3);
    check("good_nrdy_cycles", 16'(nrdy_cnt), 16'd3);
    check("good_err_cnt", 16'(ce_cnt + le_cnt), 16'd0);

    // Bad checksum, then a good frame
    zero();
    send(8'h7E); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h98);
    tick(); tick(); tick();
    check("badchk_ce_cnt", 16'(ce_cnt), 16'd1);
    check("badchk_no_valid", 16'(tv_cnt), 16'd0);
    check("badchk_no_good", 16'(fg_cnt), 16'd0);
    check("badchk_idle", {15'd0, busy}, 16'd0);
    zero();
    good_frame();
    wait_drain();
    check("after_bad_fg_cnt", 16'(fg_cnt), 16'd1);

    // Length errors: zero and MAX_LEN+1, then a one-byte frame
    zero();
    send(8'h7E); send(8'h00);
    tick();
    check("len0_le_cnt", 16'(le_cnt), 16'd1);
    send(8'h7E); send(8'h41);
    tick();
    check("len65_le_cnt", 16'(le_cnt), 16'd2);
    push_exp(8'hAA, 1'b1);
    send(8'h7E); send(8'h01); send(8'hAA); send(8'h55);
    wait_drain();
    check("len1_fg_cnt", 16'(fg_cnt), 16'd1);
    check("len_tv_cycles", 16'(tv_cnt), 16'd1);

    // Leading garbage, SOF as payload data, and downstream backpressure
    zero();
    push_exp(8'h7E, 1'b0); push_exp(8'h01, 1'b1);
    send(8'h00); send(8'hFF); send(8'h7E); send(8'h02); send(8'h7E); send(8'h01); send(8'h7F);
    tick();
    axis.m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_s_tready", {15'd0, axis.s_axis_tready}, 16'd0);
      check("stall_valid", {15'd0, axis.m_axis_tvalid}, 16'd1);
      tick();
    end
    axis.m_axis_tready = 1'b1;
    wait_drain();
    check("garbage_fg_cnt", 16'(fg_cnt), 16'd1);
    check("garbage_err_cnt", 16'(ce_cnt + le_cnt), 16'd0);

    // Inter-byte timeout
    zero();
    send(8'h7E); send(8'h03); send(8'h11);
    tick_cnt = 0;
    for (int i = 0; i < TO + 3; i++) tick();
`ifdef UART_DEFRAMER_TIMEOUT_EN
    check("to_cnt", 16'(to_cnt), 16'd1);
    check("to_timing", {15'd0, (to_cyc == TO || to_cyc == TO + 1)}, 16'd1);
    check("to_idle", {15'd0, busy}, 16'd0);
    zero();
    good_frame();
    wait_drain();
    check("after_to_fg_cnt", 16'(fg_cnt), 16'd1);
`else
    check("to_cnt", 16'(to_cnt), 16'd0);
    check("to_busy", {15'd0, busy}, 16'd1);
    push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b0); push_exp(8'h33, 1'b1);
    send(8'h22); send(8'h33); send(8'h97);
    wait_drain();
    check("resume_fg_cnt", 16'(fg_cnt), 16'd1);
`endif

    // Asynchronous reset during the second output beat
    zero();
    good_frame();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_outputs", {8'd0, axis.m_axis_tvalid, axis.m_axis_tlast, busy, frame_good,
                           checksum_error, length_error, timeout_error, 1'b0}, 16'd0);
    check("arst_tdata", {8'd0, axis.m_axis_tdata}, 16'd0);
    check("arst_s_tready", {15'd0, axis.s_axis_tready}, 16'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    zero();
    push_exp(8'hAA, 1'b1);
    send(8'h7E); send(8'h01); send(8'hAA); send(8'h55);
    wait_drain();
    check("post_rst_fg_cnt", 16'(fg_cnt), 16'd1);
    check("post_rst_sb_empty", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
